// File: rtl/reg_disp_scan.sv
// Hex display of the selected register on an 8-digit multiplexed common-anode
// seven-segment display, plus a debounced button that steps the register select.
// Optional build macro DISP_SEL_EN: digits 7..6 show reg_sel, digit 6 dp lit.
module reg_disp_scan #(
  parameter int SCAN_DIV  = 100000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_next,
  input  logic [31:0] reg_data,
  output logic [4:0]  reg_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Scan path state
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
`ifdef DISP_SEL_EN
  logic [4:0]    sel_snap_q, sel_snap_d;
`endif

  // Button path state
  logic [1:0]    sync_q;
  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    reg_sel_q;

  logic       tick;
  logic       frame_start;
  logic [3:0] nib;
  logic       dp_n;
  logic       btn_s;
  logic       step;

  assign tick        = (presc_q == PRESC_MAX);
  assign frame_start = (idx_q == 3'd0);
  assign btn_s       = sync_q[1];

  // Digit 0 reads reg_data live because the snapshot loads on that same edge.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    nib  = snap_q[{idx_q, 2'b00} +: 4];
    dp_n = 1'b1;
    if (frame_start) nib = reg_data[3:0];
`ifdef DISP_SEL_EN
    if (idx_q == 3'd6) begin
      nib  = sel_snap_q[3:0];
      dp_n = 1'b0;
    end
    if (idx_q == 3'd7) nib = {3'b000, sel_snap_q[4]};
`endif
  end

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    an_d    = an_q;
    seg_d   = seg_q;
`ifdef DISP_SEL_EN
    sel_snap_d = sel_snap_q;
`endif
    if (tick) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = {dp_n, hex7(nib)};
      idx_d = idx_q + 3'd1;
      if (frame_start) begin
        snap_d = reg_data;
`ifdef DISP_SEL_EN
        sel_snap_d = reg_sel_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the snapshot is plain data, yet it is reset so a frame never shows stale values after rstn.
    if (!rstn) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      snap_q  <= 32'h0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
`ifdef DISP_SEL_EN
      sel_snap_q <= 5'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
`ifdef DISP_SEL_EN
      sel_snap_q <= sel_snap_d;
`endif
    end
  end

  // The step fires on the edge that leaves PRESS_WAIT, giving DB_CYCLES+1 of latency.
  assign step = (state_q == PRESS_WAIT) && btn_s && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      cnt_q     <= '0;
      reg_sel_q <= 5'd0;
    end else begin
      sync_q <= {sync_q[0], btn_next};
      if (step) reg_sel_q <= reg_sel_q + 5'd1;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s)                state_q <= IDLE;
          else if (cnt_q == CNT_MAX) state_q <= HELD;
          else                       cnt_q   <= cnt_q + CW'(1);
        end
        HELD: begin
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s)                 state_q <= HELD;
          else if (cnt_q == CNT_MAX) state_q <= IDLE;
          else                       cnt_q   <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_sel = reg_sel_q;
  assign an      = an_q;
  assign seg     = seg_q;

endmodule
